// File: rtl/sram_arbiter.sv
// Two-port (video/sprite) read arbiter for an asynchronous SRAM, starvation-bounded for the sprite port.
// Latency: grant the cycle after the request is sampled, read data two cycles after the grant; one read per 2 cycles.
// Backpressure: a requester holds req until its gnt; losing or late requests wait for the next arbitration edge.
module sram_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_valid,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_gnt,
    output logic [DATA_W-1:0] spr_rdata,
    output logic              spr_valid,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t           state;
    logic             owner_spr;
    logic [CNT_W-1:0] starve_cnt;
    logic             any_req;
    logic             spr_wins;
    logic             starved;

    assign any_req  = vid_req | spr_req;
    assign starved  = (starve_cnt == CNT_W'(STARVE_MAX));
    assign spr_wins = spr_req & (~vid_req | starved);

    // Read-only port: byte lanes follow chip enable, write enable never asserts.
    assign SRAM_WE_N = 1'b1;
    assign SRAM_UB_N = SRAM_CE_N;
    assign SRAM_LB_N = SRAM_CE_N;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            owner_spr  <= 1'b0;
            starve_cnt <= '0;
            SRAM_ADDR  <= '0;
            vid_rdata  <= '0;
            spr_rdata  <= '0;
            vid_gnt    <= 1'b0;
            spr_gnt    <= 1'b0;
            vid_valid  <= 1'b0;
            spr_valid  <= 1'b0;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
        end else begin
            vid_gnt   <= 1'b0;
            spr_gnt   <= 1'b0;
            vid_valid <= 1'b0;
            spr_valid <= 1'b0;
            case (state)
                IDLE, CAPTURE: begin
                    if (state == CAPTURE) begin
                        if (owner_spr) begin
                            spr_rdata <= SRAM_DQ;
                            spr_valid <= 1'b1;
                        end else begin
                            vid_rdata <= SRAM_DQ;
                            vid_valid <= 1'b1;
                        end
                    end
                    // Arbitration edge: track how long a waiting sprite request has lost.
                    if (!spr_req || spr_wins)
                        starve_cnt <= '0;
                    else if (!starved)
                        starve_cnt <= starve_cnt + CNT_W'(1);
                    if (any_req) begin
                        state     <= ISSUE;
                        owner_spr <= spr_wins;
                        SRAM_ADDR <= spr_wins ? spr_addr : vid_addr;
                        vid_gnt   <= ~spr_wins;
                        spr_gnt   <= spr_wins;
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                default: begin
                    state     <= IDLE;
                    SRAM_CE_N <= 1'b1;
                    SRAM_OE_N <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and randomised checks of sram_arbiter against a simple SRAM model and per-port scoreboards.
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        vid_req = 1'b0, spr_req = 1'b0;
    logic [19:0] vid_addr = '0, spr_addr = '0;
    logic        vid_gnt, spr_gnt, vid_valid, spr_valid;
    logic [15:0] vid_rdata, spr_rdata;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    int checks = 0;
    int passes = 0;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .STARVE_MAX(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_valid(vid_valid),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt),
        .spr_rdata(spr_rdata), .spr_valid(spr_valid),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] mem(input logic [19:0] a);
        return (a == 20'h00123) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction

    always_comb begin
        SRAM_DQ = 16'hDEAD;
        if (!SRAM_CE_N && !SRAM_OE_N) SRAM_DQ = mem(SRAM_ADDR);
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick;
        checks++; if ({vid_gnt, spr_gnt, vid_valid, spr_valid} !== 4'b0000) $display("FAIL reset_pulses got=%b exp=0000", {vid_gnt, spr_gnt, vid_valid, spr_valid}); else passes++;
        checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111) $display("FAIL reset_ctrl got=%b exp=11111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}); else passes++;
        checks++; if ({SRAM_ADDR, vid_rdata, spr_rdata} !== 52'h0) $display("FAIL reset_data got=%h exp=0", {SRAM_ADDR, vid_rdata, spr_rdata}); else passes++;
        Reset = 1'b0;
        tick;
        checks++; if ({vid_gnt, spr_gnt, SRAM_CE_N, SRAM_OE_N} !== 4'b0011) $display("FAIL reset_idle got=%b exp=0011", {vid_gnt, spr_gnt, SRAM_CE_N, SRAM_OE_N}); else passes++;
    endtask

    task automatic test_single_read;
        vid_req = 1'b1; vid_addr = 20'h00123;
        tick;
        checks++; if ({vid_gnt, spr_gnt, SRAM_ADDR} !== {2'b10, 20'h00123}) $display("FAIL single_gnt got=%b/%h exp=10/00123", {vid_gnt, spr_gnt}, SRAM_ADDR); else passes++;
        checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N} !== 5'b00001) $display("FAIL single_ctrl got=%b exp=00001", {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N}); else passes++;
        vid_req = 1'b0;
        tick;
        checks++; if ({vid_gnt, vid_valid, SRAM_CE_N, SRAM_OE_N, SRAM_ADDR} !== {4'b0000, 20'h00123}) $display("FAIL single_capture got=%b/%h exp=0000/00123", {vid_gnt, vid_valid, SRAM_CE_N, SRAM_OE_N}, SRAM_ADDR); else passes++;
        tick;
        checks++; if ({vid_valid, spr_valid, vid_rdata} !== {2'b10, 16'hBEEF}) $display("FAIL single_valid got=%b/%h exp=10/beef", {vid_valid, spr_valid}, vid_rdata); else passes++;
        checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N} !== 3'b111) $display("FAIL single_release got=%b exp=111", {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N}); else passes++;
        tick;
        checks++; if ({vid_valid, vid_rdata} !== {1'b0, 16'hBEEF}) $display("FAIL single_hold got=%b/%h exp=0/beef", vid_valid, vid_rdata); else passes++;
    endtask

    task automatic test_contention;
        logic es, ep;
        vid_req = 1'b1; vid_addr = 20'h00200;
        spr_req = 1'b1; spr_addr = 20'h00300;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (i % 2 == 0) begin
                es = ((i / 2) % 5 == 4);
                checks++; if ({vid_gnt, spr_gnt, SRAM_ADDR} !== {~es, es, es ? 20'h00300 : 20'h00200}) $display("FAIL contend_gnt%0d got=%b/%h exp=%b", i / 2, {vid_gnt, spr_gnt}, SRAM_ADDR, {~es, es}); else passes++;
                if (i >= 2) begin
                    ep = ((i / 2 - 1) % 5 == 4);
                    checks++; if ({vid_valid, spr_valid, ep ? spr_rdata : vid_rdata} !== {~ep, ep, ep ? mem(20'h00300) : mem(20'h00200)}) $display("FAIL contend_valid%0d got=%b exp=%b", i / 2 - 1, {vid_valid, spr_valid}, {~ep, ep}); else passes++;
                end
            end else begin
                checks++; if ({vid_gnt, spr_gnt, vid_valid, spr_valid, SRAM_CE_N} !== 5'b00000) $display("FAIL contend_gap%0d got=%b exp=00000", i, {vid_gnt, spr_gnt, vid_valid, spr_valid, SRAM_CE_N}); else passes++;
            end
        end
        vid_req = 1'b0; spr_req = 1'b0;
        tick;
        checks++; if ({vid_gnt, spr_gnt, vid_valid, spr_valid, SRAM_CE_N, spr_rdata} !== {5'b00011, mem(20'h00300)}) $display("FAIL contend_last got=%b/%h exp=00011", {vid_gnt, spr_gnt, vid_valid, spr_valid, SRAM_CE_N}, spr_rdata); else passes++;
        tick;
    endtask

    task automatic test_spr_only;
        logic [19:0] ea;
        spr_req = 1'b1; spr_addr = 20'h00010;
        for (int i = 0; i < 7; i++) begin
            tick;
            checks++; if ({vid_gnt, spr_gnt, vid_valid, spr_valid} !== {1'b0, (i % 2 == 0) && (i <= 4), 1'b0, (i % 2 == 0) && (i >= 2)}) $display("FAIL spr_only_flags%0d got=%b", i, {vid_gnt, spr_gnt, vid_valid, spr_valid}); else passes++;
            if (i % 2 == 0 && i <= 4) begin
                ea = 20'h00010 + 20'(i / 2);
                checks++; if (SRAM_ADDR !== ea) $display("FAIL spr_only_addr%0d got=%h exp=%h", i / 2, SRAM_ADDR, ea); else passes++;
                spr_addr = ea + 20'h1;
                if (i == 4) spr_req = 1'b0;
            end
            if (i % 2 == 0 && i >= 2) begin
                ea = 20'h00010 + 20'(i / 2 - 1);
                checks++; if (spr_rdata !== mem(ea)) $display("FAIL spr_only_data%0d got=%h exp=%h", i / 2 - 1, spr_rdata, mem(ea)); else passes++;
            end
        end
    endtask

    task automatic test_starve_clear;
        logic es;
        vid_req = 1'b1; vid_addr = 20'h00400;
        spr_req = 1'b1; spr_addr = 20'h00500;
        for (int i = 0; i < 18; i++) begin
            tick;
            if (i % 2 == 0) begin
                es = (i == 16);
                checks++; if ({vid_gnt, spr_gnt} !== {~es, es}) $display("FAIL starve_gnt%0d got=%b exp=%b", i / 2, {vid_gnt, spr_gnt}, {~es, es}); else passes++;
            end
            if (i == 4) spr_req = 1'b0;
            if (i == 6) spr_req = 1'b1;
        end
        vid_req = 1'b0; spr_req = 1'b0;
        tick; tick; tick;
    endtask

    task automatic test_reset_mid;
        vid_req = 1'b1; vid_addr = 20'h00055;
        tick;
        vid_req = 1'b0;
        tick;
        Reset = 1'b1;
        #1;
        checks++; if ({vid_gnt, spr_gnt, vid_valid, spr_valid, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N} !== 8'b00001111) $display("FAIL midrst_ctrl got=%b exp=00001111", {vid_gnt, spr_gnt, vid_valid, spr_valid, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}); else passes++;
        checks++; if ({SRAM_ADDR, vid_rdata, spr_rdata} !== 52'h0) $display("FAIL midrst_data got=%h exp=0", {SRAM_ADDR, vid_rdata, spr_rdata}); else passes++;
        tick;
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if ({vid_gnt, spr_gnt, vid_valid, spr_valid, SRAM_CE_N} !== 5'b00001) $display("FAIL midrst_quiet%0d got=%b exp=00001", i, {vid_gnt, spr_gnt, vid_valid, spr_valid, SRAM_CE_N}); else passes++;
        end
        vid_req = 1'b1; vid_addr = 20'h00077;
        tick;
        vid_req = 1'b0;
        checks++; if ({vid_gnt, SRAM_ADDR} !== {1'b1, 20'h00077}) $display("FAIL midrst_restart got=%b/%h exp=1/00077", vid_gnt, SRAM_ADDR); else passes++;
        tick; tick;
        checks++; if ({vid_valid, vid_rdata} !== {1'b1, mem(20'h00077)}) $display("FAIL midrst_read got=%b/%h exp=1/%h", vid_valid, vid_rdata, mem(20'h00077)); else passes++;
        tick;
    endtask

    task automatic test_random;
        logic [15:0] vq[$];
        logic [15:0] sq[$];
        logic [15:0] ed;
        logic vprev, sprev;
        for (int c = 0; c < 10008; c++) begin
            vprev = vid_req; sprev = spr_req;
            tick;
            checks++; if ({vid_gnt & spr_gnt, vid_valid & spr_valid, SRAM_WE_N} !== 3'b001) $display("FAIL rand_excl c=%0d got=%b exp=001", c, {vid_gnt & spr_gnt, vid_valid & spr_valid, SRAM_WE_N}); else passes++;
            if (vid_gnt) begin
                checks++; if ({vprev, SRAM_ADDR} !== {1'b1, vid_addr}) $display("FAIL rand_vgnt c=%0d got=%b/%h exp=1/%h", c, vprev, SRAM_ADDR, vid_addr); else passes++;
                vq.push_back(mem(vid_addr));
            end
            if (spr_gnt) begin
                checks++; if ({sprev, SRAM_ADDR} !== {1'b1, spr_addr}) $display("FAIL rand_sgnt c=%0d got=%b/%h exp=1/%h", c, sprev, SRAM_ADDR, spr_addr); else passes++;
                sq.push_back(mem(spr_addr));
            end
            if (vid_valid) begin
                checks++;
                if (vq.size() == 0) $display("FAIL rand_vvalid c=%0d got=unexpected valid exp=none", c);
                else begin
                    ed = vq.pop_front();
                    if (vid_rdata !== ed) $display("FAIL rand_vdata c=%0d got=%h exp=%h", c, vid_rdata, ed); else passes++;
                end
            end
            if (spr_valid) begin
                checks++;
                if (sq.size() == 0) $display("FAIL rand_svalid c=%0d got=unexpected valid exp=none", c);
                else begin
                    ed = sq.pop_front();
                    if (spr_rdata !== ed) $display("FAIL rand_sdata c=%0d got=%h exp=%h", c, spr_rdata, ed); else passes++;
                end
            end
            if (c >= 10000) begin
                vid_req = 1'b0; spr_req = 1'b0;
            end else begin
                if (vid_req && (vid_gnt || $urandom_range(15) == 0)) vid_req = 1'b0;
                else if (!vid_req && $urandom_range(1) == 1) begin vid_req = 1'b1; vid_addr = 20'($urandom); end
                if (spr_req && (spr_gnt || $urandom_range(15) == 0)) spr_req = 1'b0;
                else if (!spr_req && $urandom_range(1) == 1) begin spr_req = 1'b1; spr_addr = 20'($urandom); end
            end
        end
        checks++; if (vq.size() + sq.size() != 0) $display("FAIL rand_drain got=%0d pending exp=0", vq.size() + sq.size()); else passes++;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_contention;
        test_spr_only;
        test_starve_clear;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
